// File: rtl/calc_op_sequencer_if.sv
// rtl/calc_op_sequencer_if.sv - request/result bundle between the calculator front-end and the arithmetic sequencer
interface calc_op_sequencer_if #(
   parameter int WIDTH = 20
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             clear;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             ovf;

   modport master (
      output start, op, a, b, clear,
      input  busy, done, result, ovf
   );

   modport slave (
      input  start, op, a, b, clear,
      output busy, done, result, ovf
   );
endinterface

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - sequenced add / shift-add multiply engine with done pulse and overflow flag
module calc_op_sequencer #(
   parameter int WIDTH = 20,
   parameter int CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   calc_op_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ADD, MUL} state_t;

   state_t               state;
   logic                 busy_q;
   logic                 done_q;
   logic                 ovf_q;
   logic [WIDTH-1:0]     result_q;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     mplier;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   acc_next;
   logic [WIDTH:0]       sum;

   // mcand/mplier double as the latched operands for ADD, so no separate a/b holding registers
   always_comb begin
      acc_next = acc;
      if (mplier[0]) acc_next = acc + mcand;
      sum = {1'b0, mcand[WIDTH-1:0]} + {1'b0, mplier};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         result_q <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.clear) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     acc    <= '0;
                     mcand  <= {{WIDTH{1'b0}}, bus.a};
                     mplier <= bus.b;
                     cnt    <= '0;
                     busy_q <= 1'b1;
                     state  <= bus.op ? MUL : ADD;
                  end
               end
               ADD: begin
                  {ovf_q, result_q} <= sum;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
               MUL: begin
                  acc    <= acc_next;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
                  // fixed WIDTH iterations; the last one is folded in through acc_next
                  if (cnt == CNT_W'(WIDTH - 1)) begin
                     result_q <= acc_next[WIDTH-1:0];
                     ovf_q    <= |acc_next[2*WIDTH-1:WIDTH];
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     state    <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - randomized and directed bench for calc_op_sequencer against a cycle-level behavioural model
module tb_calc_op_sequencer;
   localparam int W  = 20;
   localparam int CW = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   calc_op_sequencer_if #(.WIDTH(W)) bus ();

   calc_op_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // model: an accepted request yields its full-precision answer after a fixed number of edges
   logic          m_busy;
   logic          m_done;
   logic [W-1:0]  m_result;
   logic          m_ovf;
   int            m_left;
   logic [63:0]   m_pend;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy = 0; m_done = 0; m_result = '0; m_ovf = 0; m_left = 0; m_pend = '0;
      end else begin
         m_done = 0;
         if (bus.clear) begin
            m_busy = 0; m_left = 0; m_result = '0; m_ovf = 0;
         end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy   = 0;
               m_done   = 1;
               m_result = m_pend[W-1:0];
               m_ovf    = (m_pend >> W) != 0;
            end
         end else if (bus.start) begin
            m_busy = 1;
            m_left = bus.op ? W : 1;
            m_pend = bus.op ? 64'(bus.a) * 64'(bus.b) : 64'(bus.a) + 64'(bus.b);
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         n_checks++;
         if ({bus.busy, bus.done, bus.result, bus.ovf} !== {m_busy, m_done, m_result, m_ovf}) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t busy/done/result/ovf got %b/%b/%h/%b exp %b/%b/%h/%b",
                     $time, bus.busy, bus.done, bus.result, bus.ovf, m_busy, m_done, m_result, m_ovf);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      step();
      bus.start = 1'b0;
   endtask

   // operands are scrambled while waiting to show they are not re-sampled
   task automatic wait_done(input string name, input int max, output int lat);
      lat = 0;
      while (!m_done && lat < max) begin
         step();
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         lat++;
      end
      if (!m_done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout got no done exp done within %0d", name, max);
      end
   endtask

   int lat;
   int dones;

   initial begin
      bus.start = 0; bus.op = 0; bus.a = '0; bus.b = '0; bus.clear = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.ovf}, '0);
      step();
      rst = 1'b1;
      step();

      issue(1'b0, 20'h12345, 20'h54321);
      chk("plus1_busy", bus.busy, 1);
      wait_done("plus1", 5, lat);
      chk("plus1_lat", lat, 1);
      chk("plus1_result", bus.result, 20'h66666);
      chk("plus1_ovf", bus.ovf, 0);
      chk("plus1_model", m_result, 20'h66666);

      issue(1'b0, 20'hFFFFF, 20'h00001);
      wait_done("plus2", 5, lat);
      chk("plus_wrap_result", bus.result, 20'h00000);
      chk("plus_wrap_ovf", bus.ovf, 1);
      issue(1'b0, 20'h00001, 20'h00001);
      wait_done("plus3", 5, lat);
      chk("plus3_result", bus.result, 20'h00002);
      chk("plus3_ovf", bus.ovf, 0);

      issue(1'b1, 20'h00123, 20'h00456);
      wait_done("mul1", 30, lat);
      chk("mul1_lat", lat, 20);
      chk("mul1_result", bus.result, 20'h4EDC2);
      chk("mul1_ovf", bus.ovf, 0);
      chk("mul1_model", m_result, 20'h4EDC2);

      issue(1'b1, 20'h00400, 20'h00400);
      wait_done("mul2", 30, lat);
      chk("mul_wrap_result", bus.result, 20'h00000);
      chk("mul_wrap_ovf", bus.ovf, 1);
      issue(1'b1, 20'hFFFFF, 20'h00000);
      wait_done("mul3", 30, lat);
      chk("mul_zero_lat", lat, 20);
      chk("mul_zero_result", bus.result, 20'h00000);
      chk("mul_zero_ovf", bus.ovf, 0);

      issue(1'b1, 20'h00ABC, 20'h00DEF);
      repeat (3) step();
      issue(1'b0, 20'h11111, 20'h22222);
      repeat (4) step();
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      chk("clear_busy", bus.busy, 0);
      chk("clear_result", bus.result, 0);
      chk("clear_ovf", bus.ovf, 0);
      dones = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.done) dones++;
      end
      chk("clear_no_done", dones, 0);
      bus.start = 1'b1; bus.clear = 1'b1; bus.op = 1'b0; bus.a = 20'h5; bus.b = 20'h6;
      step();
      bus.start = 1'b0; bus.clear = 1'b0;
      chk("clear_start_busy", bus.busy, 0);
      step();
      chk("clear_start_done", bus.done, 0);

      issue(1'b1, 20'h00321, 20'h00123);
      repeat (5) step();
      #1;
      rst = 1'b0;
      #1;
      chk("async_reset", {bus.busy, bus.done, bus.result, bus.ovf}, '0);
      step();
      step();
      rst = 1'b1;
      step();
      issue(1'b0, 20'h00007, 20'h00008);
      wait_done("plus_after_rst", 5, lat);
      chk("plus_after_rst_result", bus.result, 20'h0000F);
      issue(1'b1, 20'h00010, 20'h00020);
      chk("b2b_busy", bus.busy, 1);
      wait_done("b2b_mul", 30, lat);
      chk("b2b_lat", lat, 20);
      chk("b2b_result", bus.result, 20'h00200);

      for (int i = 0; i < 1500; i++) begin
         bus.start = ($urandom_range(0, 2) == 0);
         bus.clear = ($urandom_range(0, 60) == 0);
         bus.op    = 1'($urandom);
         case ($urandom_range(0, 4))
            0: bus.a = 20'hFFFFF;
            1: bus.a = '0;
            2: bus.a = W'($urandom_range(0, 1023));
            default: bus.a = W'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: bus.b = 20'hFFFFF;
            1: bus.b = '0;
            2: bus.b = W'($urandom_range(0, 1023));
            default: bus.b = W'($urandom);
         endcase
         step();
      end
      bus.start = 0; bus.clear = 0;
      repeat (25) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
